// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART debug-path serializers (TX now, RX later).
// State encodings, parity modes and baud-period arithmetic live here so both directions agree.
package uart_tx_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per UART bit; integer division, caller guarantees result >= 2.
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: one character per send/ready handshake, framed as
// start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits. Outputs registered.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       i_top_clk,
  input  logic       i_top_rst,
  input  logic       i_send,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_uart_txd
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ_HZ, BAUD_RATE);
  localparam int TMR_W      = $clog2(BIT_CYCLES);

  localparam logic [TMR_W-1:0] TMR_TC   = TMR_W'(BIT_CYCLES - 1);
  localparam logic [2:0]       STOP_LST = 3'(STOP_BITS - 1);

  tx_state_e        r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_par_bit;
  logic             r_ready;
  logic             r_txd;

  tx_state_e        w_state_nxt;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_par_bit_nxt;
  logic             w_ready_nxt;
  logic             w_txd_nxt;
  logic             w_tmr_tc;

  assign w_tmr_tc = (r_tmr == TMR_TC);

  always_ff @(posedge i_top_clk or negedge i_top_rst) begin
    if (!i_top_rst) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_ready   <= 1'b1;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_ready   <= w_ready_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_par_bit_nxt = r_par_bit;

    case (r_state)
      ST_IDLE: begin
        w_tmr_nxt     = '0;
        w_bit_idx_nxt = '0;
        if (i_send) begin
          w_shift_nxt   = i_data;
          // Parity is frozen at capture so later i_data changes cannot leak in.
          w_par_bit_nxt = (PARITY_MODE == PAR_ODD) ? ~(^i_data) : (^i_data);
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (w_tmr_tc) begin
          w_tmr_nxt   = '0;
          w_state_nxt = ST_DATA;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_tmr_tc) begin
          w_tmr_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      ST_PARITY: begin
        if (w_tmr_tc) begin
          w_tmr_nxt   = '0;
          w_state_nxt = ST_STOP;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_tmr_tc) begin
          w_tmr_nxt = '0;
          if (r_bit_idx == STOP_LST) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_tmr_nxt     = '0;
        w_bit_idx_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the line and
  // ready flag change on the same edge that moves the FSM.
  always_comb begin
    w_ready_nxt = 1'b0;
    w_txd_nxt   = 1'b1;
    case (w_state_nxt)
      ST_IDLE:   w_ready_nxt = 1'b1;
      ST_START:  w_txd_nxt   = 1'b0;
      ST_DATA:   w_txd_nxt   = w_shift_nxt[0];
      ST_PARITY: w_txd_nxt   = w_par_bit_nxt;
      ST_STOP:   w_txd_nxt   = 1'b1;
      default: begin
        w_ready_nxt = 1'b1;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  assign o_ready    = r_ready;
  assign o_uart_txd = r_txd;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at 4 clocks/bit; four instances cover
// no parity/1 stop, odd, even, and no parity/2 stop.
module tb_uart_tx_serializer;

  localparam int BC = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic [3:0] send_v;
  logic [3:0] ready_v;
  logic [3:0] txd_v;

  int n_tests = 0;
  int n_fail  = 0;
  logic q_bits[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .PARITY_MODE(0), .STOP_BITS(1)) u_none1 (
    .i_top_clk(clk), .i_top_rst(rst_n), .i_send(send_v[0]), .i_data(data),
    .o_ready(ready_v[0]), .o_uart_txd(txd_v[0]));
  uart_tx_serializer #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .PARITY_MODE(1), .STOP_BITS(1)) u_odd (
    .i_top_clk(clk), .i_top_rst(rst_n), .i_send(send_v[1]), .i_data(data),
    .o_ready(ready_v[1]), .o_uart_txd(txd_v[1]));
  uart_tx_serializer #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .PARITY_MODE(2), .STOP_BITS(1)) u_even (
    .i_top_clk(clk), .i_top_rst(rst_n), .i_send(send_v[2]), .i_data(data),
    .o_ready(ready_v[2]), .o_uart_txd(txd_v[2]));
  uart_tx_serializer #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .PARITY_MODE(0), .STOP_BITS(2)) u_none2 (
    .i_top_clk(clk), .i_top_rst(rst_n), .i_send(send_v[3]), .i_data(data),
    .o_ready(ready_v[3]), .o_uart_txd(txd_v[3]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s ready%0d", tag, k), ready_v[k], 1'b1);
      chk($sformatf("%s txd%0d", tag, k), txd_v[k], 1'b1);
    end
  endtask

  // Drive a request (called just after a negedge) and push the expected line bits.
  task automatic launch(input int k, input logic [7:0] d);
    int par;
    int stops;
    par   = (k == 1) ? 1 : (k == 2) ? 2 : 0;
    stops = (k == 3) ? 2 : 1;
    data      = d;
    send_v[k] = 1'b1;
    q_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) q_bits.push_back(d[i]);
    if (par == 1) q_bits.push_back(~(^d));
    if (par == 2) q_bits.push_back(^d);
    for (int i = 0; i < stops; i++) q_bits.push_back(1'b1);
  endtask

  // Pop each expected bit and compare the line every cycle it is held; ready must
  // stay low for the whole frame and return high on the following cycle.
  task automatic expect_frame(input int k, input logic keep, input int poke_at,
                              input logic [7:0] poke_data, input string tag);
    int   cyc;
    logic e;
    cyc = 0;
    while (q_bits.size() > 0) begin
      e = q_bits.pop_front();
      for (int j = 0; j < BC; j++) begin
        @(negedge clk);
        chk($sformatf("%s txd c%0d", tag, cyc), txd_v[k], e);
        chk($sformatf("%s busy c%0d", tag, cyc), ready_v[k], 1'b0);
        if (cyc == 0 && !keep) send_v[k] = 1'b0;
        if (cyc == poke_at) begin
          data      = poke_data;
          send_v[k] = 1'b1;
        end
        if (cyc == poke_at + 1) send_v[k] = keep;
        cyc++;
      end
    end
    @(negedge clk);
    chk($sformatf("%s ready end", tag), ready_v[k], 1'b1);
    chk($sformatf("%s txd end", tag), txd_v[k], 1'b1);
  endtask

  initial begin
    rst_n  = 1'b0;
    send_v = '0;
    data   = 8'h00;

    // Reset held for 5 cycles, then released with no request.
    repeat (5) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("post reset");
    end

    // Basic frame, no parity, 1 stop: 'A'.
    launch(0, 8'h41);
    expect_frame(0, 1'b0, -1, 8'h00, "basic41");

    // Odd and even parity on 'A'.
    launch(1, 8'h41);
    expect_frame(1, 1'b0, -1, 8'h00, "odd41");
    launch(2, 8'h41);
    expect_frame(2, 1'b0, -1, 8'h00, "even41");
    launch(2, 8'hB7);
    expect_frame(2, 1'b0, -1, 8'h00, "evenB7");

    // Busy rejection: '0' sent, '9' pulsed mid-DATA must be dropped.
    launch(0, 8'h30);
    expect_frame(0, 1'b0, 20, 8'h39, "busy30");
    repeat (8) begin
      @(negedge clk);
      chk("no second frame ready", ready_v[0], 1'b1);
      chk("no second frame txd", txd_v[0], 1'b1);
    end

    // Back-to-back with send held, 2 stop bits; data changes mid-frame to the next char.
    launch(3, 8'h0A);
    expect_frame(3, 1'b1, 10, 8'h0D, "b2b0A");
    launch(3, 8'h0D);
    expect_frame(3, 1'b0, -1, 8'h00, "b2b0D");
    repeat (4) begin
      @(negedge clk);
      chk("b2b idle after", ready_v[3], 1'b1);
    end

    // Reset during data bit 3 of 'U'.
    data      = 8'h55;
    send_v[0] = 1'b1;
    @(negedge clk);
    send_v[0] = 1'b0;
    chk("rst55 start bit", txd_v[0], 1'b0);
    repeat (17) @(negedge clk);
    chk("rst55 bit3", txd_v[0], 1'b0);
    chk("rst55 busy", ready_v[0], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst55 async txd", txd_v[0], 1'b1);
    chk("rst55 async ready", ready_v[0], 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst55 released");
    launch(0, 8'h55);
    expect_frame(0, 1'b0, -1, 8'h00, "after rst55");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
